// File: rtl/adc_sample_scheduler.sv
// ADC sample scheduler: paces single-slot ADC commands at a fixed sample rate, captures the
// matching response and forwards it on a framed valid/ready sample stream.
module adc_sample_scheduler #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SAMPLE_HZ   = 8000,
  parameter int unsigned CHANNEL     = 1,
  parameter int unsigned FRAME_LEN   = 1024,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        cmd_valid,
  output logic [4:0]  cmd_channel,
  output logic        cmd_sop,
  output logic        cmd_eop,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  output logic [11:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        sample_sof,
  output logic        sample_eof,
  output logic [15:0] overrun_cnt,
  output logic [15:0] timeout_cnt,
  output logic        busy
);

  localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned IW  = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StOutput} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [11:0] sample_q, sample_d;
  logic [15:0] ovr_q, ovr_d;
  logic [15:0] to_q, to_d;
  logic        enable_q;
  logic        tick;
  logic        rsp_match;

  // State and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      sample_q <= '0;
      ovr_q    <= '0;
      to_q     <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      ovr_q    <= ovr_d;
      to_q     <= to_d;
      enable_q <= enable;
    end
  end

  // Tick generation, FSM next state, frame index and saturating event counters
  always_comb begin
    tick      = enable && (cnt_q == CW'(DIV - 1));
    rsp_match = rsp_valid && (rsp_channel == 5'(CHANNEL));
    cnt_d     = '0;
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    sample_d  = sample_q;
    ovr_d     = ovr_q;
    to_d      = to_q;

    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StIssue;
      end
      StIssue: begin
        if (cmd_ready) begin
          state_d = StWaitRsp;
          timer_d = '0;
        end
      end
      StWaitRsp: begin
        if (rsp_match) begin
          sample_d = rsp_data;
          state_d  = StOutput;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = StIdle;
          if (to_q != 16'hFFFF) to_d = to_q + 16'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StOutput: begin
        if (sample_ready) begin
          state_d = StIdle;
          idx_d   = (idx_q == IW'(FRAME_LEN - 1)) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick outside IDLE (including the cycle a sample leaves) is dropped
    if (tick && (state_q != StIdle) && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;

    // Restarting begins a fresh frame; takes priority over a coincident advance
    if (enable && !enable_q) idx_d = '0;
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    cmd_valid    = (state_q == StIssue);
    cmd_sop      = cmd_valid;
    cmd_eop      = cmd_valid;
    cmd_channel  = cmd_valid ? 5'(CHANNEL) : 5'd0;
    sample_valid = (state_q == StOutput);
    sample       = sample_q;
    sample_sof   = sample_valid && (idx_q == '0);
    sample_eof   = sample_valid && (idx_q == IW'(FRAME_LEN - 1));
    overrun_cnt  = ovr_q;
    timeout_cnt  = to_q;
    busy         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler (DIV=10, FRAME_LEN=4, TIMEOUT_CYC=8, CHANNEL=1).
module tb_adc_sample_scheduler;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic [4:0]  cmd_channel;
  logic        cmd_sop;
  logic        cmd_eop;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_sof;
  logic        sample_eof;
  logic [15:0] overrun_cnt;
  logic [15:0] timeout_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int cyc      = 0;
  int exp_idx  = 0;
  int n_data   = 0;
  int mode     = 0;  // 0: respond with data n, 1: never respond, 2: ch3 then ch1 12'hABC
  logic [13:0] sb_q[$];
  int deliv_cyc[$];

  adc_sample_scheduler #(
    .CLK_HZ(100), .SAMPLE_HZ(10), .CHANNEL(1), .FRAME_LEN(FL), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
    .rsp_data(rsp_data), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_sof(sample_sof), .sample_eof(sample_eof),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] d);
    sb_q.push_back({exp_idx == 0, exp_idx == FL - 1, d});
    exp_idx = (exp_idx + 1) % FL;
  endtask

  // ADC model: answers one cycle after each command accept
  initial begin : adc_model
    int stage;
    stage = 0;
    rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
    forever begin
      @(negedge clk); #1;
      rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
      if (reset) begin
        stage = 0;
      end else begin
        if (stage == 1) begin
          stage = 0;
          if (mode == 0) begin
            rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'(n_data);
            push_exp(12'(n_data));
            n_data++;
          end else if (mode == 2) begin
            rsp_valid = 1'b1; rsp_channel = 5'd3; rsp_data = 12'h123;
            stage = 2;
          end
        end else if (stage == 2) begin
          rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'hABC;
          push_exp(12'hABC);
          stage = 0;
        end
        if (cmd_valid && cmd_ready) begin
          stage = 1;
          check("cmd_fields", {cmd_channel, cmd_sop, cmd_eop}, {5'd1, 1'b1, 1'b1});
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every sample transfer
  initial begin : monitor
    logic [13:0] e;
    forever begin
      @(negedge clk); #2;
      if (!reset && sample_valid && sample_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: got sample %0h, expected none", sample);
        end else begin
          e = sb_q.pop_front();
          check("sb_sample", {18'd0, sample_sof, sample_eof, sample}, {18'd0, e});
        end
        n_deliv++;
        deliv_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_deliv(input string name, input int target, input int budget);
    int k = 0;
    while (n_deliv < target && k < budget) begin
      @(negedge clk); k++;
    end
    check(name, n_deliv >= target, 1);
  endtask

  task automatic wait_cmd(input string name, input int exp_k);
    int k = 0;
    while (!cmd_valid && k < 50) begin
      @(negedge clk); k++;
    end
    check(name, k, exp_k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sb_q.delete(); exp_idx = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stim
    int k;
    int bad;
    logic [11:0] held;
    logic flag;
    reset = 1'b1; enable = 1'b0; cmd_ready = 1'b0; sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {cmd_valid, sample_valid, sample_sof, sample_eof, busy, sample},
          32'd0);
    check("rst_counters", {overrun_cnt, timeout_cnt}, 32'd0);

    // Streaming: one sample per 10 cycles, sof/eof framing via scoreboard
    enable = 1'b1; cmd_ready = 1'b1; sample_ready = 1'b1; reset = 1'b0;
    wait_cmd("first_cmd_latency", 10);
    wait_deliv("stream_12", 12, 200);
    bad = 0;
    for (int i = 1; i < 12; i++) if (deliv_cyc[i] - deliv_cyc[i-1] != 10) bad++;
    check("stream_period", bad, 0);
    check("stream_overrun", overrun_cnt, 0);

    // Reset while a sample is presented
    @(negedge clk); sample_ready = 1'b0;
    k = 0;
    while (!sample_valid && k < 20) begin @(negedge clk); k++; end
    check("reach_output", sample_valid, 1);
    reset = 1'b1; sb_q.delete(); exp_idx = 0;
    #1;
    check("midout_rst_outputs", {cmd_valid, sample_valid, sample_sof, sample_eof, busy, sample},
          32'd0);
    check("midout_rst_counters", {overrun_cnt, timeout_cnt}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    wait_cmd("restart_cmd_latency", 10);

    // Sink stall for 25 cycles: data stable, two ticks dropped
    k = 0;
    while (!sample_valid && k < 10) begin @(negedge clk); k++; end
    check("stall_valid_latency", k, 2);
    held = sample; flag = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (!sample_valid || sample != held) flag = 1'b0;
    end
    check("stall_stable", flag, 1);
    check("stall_overrun", overrun_cnt, 2);
    sample_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!sample_valid && k < 50);
    check("post_stall_next_valid", k, 5);
    wait_deliv("post_stall_deliv", 14, 10);

    // No responses: one timeout per period, no sample, index untouched
    mode = 1;
    do_reset();
    wait_cmd("to_first_cmd", 10);
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) flag = 1'b1;
    end
    check("to_count", timeout_cnt, 3);
    check("to_no_sample", flag, 0);
    check("to_overrun", overrun_cnt, 0);
    mode = 0;  // command pending now gets answered; expects sof (index still 0)
    wait_deliv("to_then_deliv", 15, 20);

    // Foreign-channel response ignored
    mode = 2;
    wait_deliv("chan_deliv", 16, 30);
    check("chan_timeout", timeout_cnt, 3);
    mode = 0;

    // Enable dropped in WAIT_RSP: pending sample completes, restart starts a fresh frame
    k = 0;
    while (!(cmd_valid && cmd_ready) && k < 30) begin @(negedge clk); k++; end
    @(negedge clk);
    enable = 1'b0;
    wait_deliv("en_low_pending", 17, 10);
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_valid) flag = 1'b1;
    end
    check("en_low_no_cmd", flag, 0);
    enable = 1'b1; exp_idx = 0;
    wait_deliv("en_restart_deliv", 18, 30);
    check("final_overrun", overrun_cnt, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
